// File: rtl/shift_serializer_pkg.sv
// Shared constants and helpers for the left shifter and its serializer stage.
package shift_serializer_pkg;

  // Parallel word width used by default across the shifter datapath.
  localparam int DEFAULT_WIDTH = 8;

  // Length counter width for the default word width (counts 0..width).
  localparam int LEN_W = 4;

  // Serializer states, derived from the remaining-bit counter.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  // Ceiling log2; clog2(1) is 0.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

  // Limit a requested bit count to the word width.
  function automatic int clamp_len(input int len, input int w);
    return (len > w) ? w : len;
  endfunction

endpackage

// File: rtl/shift_serializer.sv
// MSB-first parallel-to-serial stage with valid/ready on both sides.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; the producer holds data stable while valid is high and ready is low, and
// o_valid never drops while a word is still being emitted.
module shift_serializer
  import shift_serializer_pkg::*;
#(
  parameter int width = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [width-1:0]                i_bits,
  input  logic [clog2(width+1)-1:0]       i_len,
  input  logic                            i_valid,
  output logic                            i_ready,
  output logic                            o_bit,
  output logic                            o_valid,
  input  logic                            o_ready,
  output logic                            o_last,
  output logic                            busy
);

  localparam int LW = clog2(width + 1);
  localparam logic [LW-1:0] ONE = LW'(1);

  logic [width-1:0] shreg;
  logic [width-1:0] shreg_next;
  logic [LW-1:0]    rem;
  logic [LW-1:0]    rem_next;
  logic             accept;
  logic             xfer;
  ser_state_t       state;

  // Remaining-bit count is the state register; IDLE when it is zero.
  assign state   = (rem != '0) ? SHIFT : IDLE;
  assign busy    = (state == SHIFT);
  assign o_valid = busy;
  assign o_bit   = shreg[width-1];
  assign o_last  = (rem == ONE);
  // Accept while idle, or while the last bit of the held word leaves this cycle.
  assign i_ready = (state == IDLE) || (o_last && o_ready);

  // Next-state: shift on output transfer, reload on input accept (reload wins).
  always_comb begin
    shreg_next = shreg;
    rem_next   = rem;
    accept     = i_valid && i_ready;
    xfer       = o_valid && o_ready;
    if (xfer) begin
      shreg_next = shreg << 1;
      rem_next   = rem - ONE;
    end
    // A zero-length word is consumed without touching the word in flight.
    if (accept && (i_len != '0)) begin
      shreg_next = i_bits;
      rem_next   = LW'(clamp_len(int'(i_len), width));
    end
  end

  // State register; reset discards any word in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      rem   <= '0;
    end else begin
      shreg <= shreg_next;
      rem   <= rem_next;
    end
  end

endmodule

// File: tb/tb_shift_serializer.sv
// Bench for shift_serializer: directed vector table, hand-written corner
// sequences, and a randomized run checked against a bit-queue reference model.
module tb_shift_serializer;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] i_bits;
  logic [3:0]   i_len;
  logic         i_valid;
  logic         i_ready;
  logic         o_bit;
  logic         o_valid;
  logic         o_ready;
  logic         o_last;
  logic         busy;

  int n_tests;
  int n_fail;

  // Reference model: queue of pending {bit, last} pairs, MSB first.
  logic [1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] bits;
    logic [3:0]   len;
    int           exp_n;
    logic [15:0]  exp_word;
  } vec_t;

  vec_t vecs[8];

  shift_serializer #(.width(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_bits  (i_bits),
    .i_len   (i_len),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .o_bit   (o_bit),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_last  (o_last),
    .busy    (busy)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] b, input logic [3:0] l, input logic r);
    i_valid = v;
    i_bits  = b;
    i_len   = l;
    o_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every cycle out of reset, compare outputs with the bit queue.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      logic mdl_ready;
      int   n;
      mdl_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && o_ready);
      chk("m_valid", o_valid, exp_q.size() != 0);
      chk("m_busy", busy, exp_q.size() != 0);
      chk("m_i_ready", i_ready, mdl_ready);
      if (exp_q.size() != 0) begin
        chk("m_bit", o_bit, exp_q[0][1]);
        chk("m_last", o_last, exp_q[0][0]);
        if (o_ready) void'(exp_q.pop_front());
      end
      if (i_valid && mdl_ready) begin
        n = (int'(i_len) > W) ? W : int'(i_len);
        for (int k = 0; k < n; k++) exp_q.push_back({i_bits[W-1-k], (k == n - 1) ? 1'b1 : 1'b0});
      end
    end
  end

  // Accept one word with o_ready high and collect everything it emits.
  task automatic run_vec(input vec_t v, input string tag);
    logic [15:0] got;
    int n, lasts, last_at;
    drive(1'b1, v.bits, v.len, 1'b1);
    @(negedge clk);
    chk({tag, "_accept_rdy"}, i_ready, 1);
    tick();
    drive(1'b0, '0, '0, 1'b1);
    got = '0; n = 0; lasts = 0; last_at = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (o_valid) begin
        got = {got[14:0], o_bit};
        n++;
        if (o_last) begin
          lasts++;
          last_at = n;
        end
      end
      tick();
    end
    chk({tag, "_count"}, n, v.exp_n);
    chk({tag, "_word"}, got, v.exp_word);
    chk({tag, "_last_pulses"}, lasts, (v.exp_n != 0) ? 1 : 0);
    chk({tag, "_last_pos"}, last_at, v.exp_n);
  endtask

  initial begin
    logic [7:0] seq;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0);

    vecs[0] = '{bits: 8'hA5, len: 4'd8,  exp_n: 8, exp_word: 16'h00A5};
    vecs[1] = '{bits: 8'hF0, len: 4'd3,  exp_n: 3, exp_word: 16'h0007};
    vecs[2] = '{bits: 8'hC3, len: 4'd0,  exp_n: 0, exp_word: 16'h0000};
    vecs[3] = '{bits: 8'hFF, len: 4'd15, exp_n: 8, exp_word: 16'h00FF};
    vecs[4] = '{bits: 8'h80, len: 4'd1,  exp_n: 1, exp_word: 16'h0001};
    vecs[5] = '{bits: 8'h3C, len: 4'd4,  exp_n: 4, exp_word: 16'h0003};
    vecs[6] = '{bits: 8'hB7, len: 4'd5,  exp_n: 5, exp_word: 16'h0016};
    vecs[7] = '{bits: 8'h01, len: 4'd9,  exp_n: 8, exp_word: 16'h0001};

    // Reset values
    #3;
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_bit", o_bit, 0);
    chk("rst_o_last", o_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_i_ready", i_ready, 1);
    tick();
    tick();
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // A5 length 8: explicit bit-by-bit sequence and i_ready profile
    seq = 8'hA5;
    drive(1'b1, 8'hA5, 4'd8, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("a5_bit%0d", k), o_bit, seq[7-k]);
      chk($sformatf("a5_last%0d", k), o_last, k == 7);
      chk($sformatf("a5_rdy%0d", k), i_ready, k == 7);
      tick();
    end
    chk("a5_done_busy", busy, 0);

    // F0 length 3 with stalls: o_ready 1,0,0,1,1
    drive(1'b1, 8'hF0, 4'd3, 1'b1);
    tick();
    drive(1'b0, 8'h0F, '0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      o_ready = (k == 1 || k == 2) ? 1'b0 : 1'b1;
      @(negedge clk);
      chk($sformatf("stall_bit%0d", k), o_bit, 1);
      chk($sformatf("stall_last%0d", k), o_last, k == 4);
      chk($sformatf("stall_valid%0d", k), o_valid, 1);
      tick();
    end
    chk("stall_done_busy", busy, 0);

    // Back-to-back: 80/len1 then 40/len2 with i_valid held
    drive(1'b1, 8'h80, 4'd1, 1'b1);
    tick();
    drive(1'b1, 8'h40, 4'd2, 1'b1);
    @(negedge clk);
    chk("b2b_bit0", o_bit, 1);
    chk("b2b_last0", o_last, 1);
    chk("b2b_rdy0", i_ready, 1);
    tick();
    drive(1'b0, '0, '0, 1'b1);
    @(negedge clk);
    chk("b2b_valid1", o_valid, 1);
    chk("b2b_bit1", o_bit, 0);
    chk("b2b_last1", o_last, 0);
    tick();
    @(negedge clk);
    chk("b2b_bit2", o_bit, 1);
    chk("b2b_last2", o_last, 1);
    tick();
    chk("b2b_done_busy", busy, 0);

    // Zero-length word arriving on the final bit of a word in flight
    drive(1'b1, 8'hC0, 4'd2, 1'b1);
    tick();
    tick();
    drive(1'b1, 8'hFF, 4'd0, 1'b1);
    @(negedge clk);
    chk("zl_last", o_last, 1);
    chk("zl_bit", o_bit, 1);
    tick();
    drive(1'b0, '0, '0, 1'b1);
    @(negedge clk);
    chk("zl_idle", busy, 0);
    tick();

    // Asynchronous reset after 3 of 8 bits
    drive(1'b1, 8'hA5, 4'd8, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b1);
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_o_valid", o_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_i_ready", i_ready, 1);
    chk("arst_o_bit", o_bit, 0);
    tick();
    rst = 1'b0;
    run_vec('{bits: 8'h3C, len: 4'd8, exp_n: 8, exp_word: 16'h003C}, "post_rst");

    // Randomized traffic checked by the scoreboard
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 1) == 1, 8'($urandom), 4'($urandom_range(0, 15)),
            $urandom_range(0, 3) != 0);
      tick();
    end
    // Drain
    drive(1'b0, '0, '0, 1'b1);
    for (int c = 0; c < 12; c++) tick();
    @(negedge clk);
    chk("drain_busy", busy, 0);
    chk("drain_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
